traffic_request_frontend: RTL and testbench

//  Input-side front end for traffic_controller; sits between the pads and the controller's walk_button/sensor inputs.

---
 rtl/traffic_pkg.sv | 32 +++
 rtl/req_sync.sv | 32 +++
 rtl/traffic_request_frontend.sv | 156 +++++++++++++++
 tb/tb_traffic_request_frontend.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// ============================================================================
// Module      : traffic_pkg
// Description : Shared walk-FSM state encoding, light colours and default
//               timing constants for the traffic controller and its front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

  typedef enum logic [1:0] {
    W_IDLE     = 2'd0,
    W_DEBOUNCE = 2'd1,
    W_PENDING  = 2'd2,
    W_SERVE    = 2'd3
  } walk_state_e;

  typedef enum logic [1:0] {
    LIGHT_RED    = 2'd0,
    LIGHT_YELLOW = 2'd1,
    LIGHT_GREEN  = 2'd2
  } light_e;

  localparam int DEF_DEBOUNCE_CYC = 2;
  localparam int DEF_SENSOR_ON    = 3;
  localparam int DEF_SENSOR_OFF   = 2;
  localparam int DEF_WAIT_W       = 8;
  localparam int DEF_STALE_LIMIT  = 30;

endpackage

`default_nettype wire

// File: rtl/req_sync.sv
// ============================================================================
// Module      : req_sync
// Description : Two-flop synchroniser for one asynchronous input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/traffic_request_frontend.sv
// ============================================================================
// Module      : traffic_request_frontend
// Description : Button debounce / request hold and car-sensor hysteresis in
//               front of traffic_controller, plus a walk-wait age counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_request_frontend
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int SENSOR_ON    = DEF_SENSOR_ON,
  parameter int SENSOR_OFF   = DEF_SENSOR_OFF,
  parameter int WAIT_W       = DEF_WAIT_W,
  parameter int STALE_LIMIT  = DEF_STALE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              walk_raw,
  input  logic              sensor_raw,
  input  logic              walk_light,
  output logic              walk_button,
  output logic              sensor_q,
  output logic [WAIT_W-1:0] walk_wait,
  output logic              walk_stale
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int ON_W   = $clog2(SENSOR_ON + 1);
  localparam int OFF_W  = $clog2(SENSOR_OFF + 1);

  // Counters hold samples already seen, so the current sample completes the run
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [ON_W-1:0]   ON_LAST   = ON_W'(SENSOR_ON - 1);
  localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(SENSOR_OFF - 1);
  localparam logic [WAIT_W:0]   STALE_C   = (WAIT_W + 1)'(STALE_LIMIT);

  logic w_s;
  logic s_s;

  req_sync u_walk_sync (
    .clk (clk),
    .rst (rst),
    .d_i (walk_raw),
    .q_o (w_s)
  );

  req_sync u_sensor_sync (
    .clk (clk),
    .rst (rst),
    .d_i (sensor_raw),
    .q_o (s_s)
  );

  walk_state_e       state_q;
  logic [DCNT_W-1:0] dcnt_q;
  logic [WAIT_W-1:0] wait_q;
  logic              button_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= W_IDLE;
      dcnt_q   <= '0;
      wait_q   <= '0;
      button_q <= 1'b0;
    end else begin
      case (state_q)
        W_IDLE: begin
          if (w_s) begin
            wait_q <= '0;
            if (DEBOUNCE_CYC == 1) begin
              state_q  <= W_PENDING;
              button_q <= 1'b1;
              dcnt_q   <= '0;
            end else begin
              state_q <= W_DEBOUNCE;
              dcnt_q  <= DCNT_W'(1);
            end
          end
        end
        W_DEBOUNCE: begin
          if (!w_s) begin
            state_q <= W_IDLE;
            dcnt_q  <= '0;
          end else if (dcnt_q == DCNT_LAST) begin
            state_q  <= W_PENDING;
            button_q <= 1'b1;
            dcnt_q   <= '0;
          end else begin
            dcnt_q <= dcnt_q + DCNT_W'(1);
          end
        end
        W_PENDING: begin
          if (wait_q != '1) begin
            wait_q <= wait_q + WAIT_W'(1);
          end
          if (walk_light) begin
            state_q  <= W_SERVE;
            button_q <= 1'b0;
          end
        end
        W_SERVE: begin
          // A button still held from the served request must be released first
          if (!walk_light && !w_s) begin
            state_q <= W_IDLE;
          end
        end
        default: begin
          state_q  <= W_IDLE;
          button_q <= 1'b0;
        end
      endcase
    end
  end

  logic [ON_W-1:0]  on_cnt_q;
  logic [OFF_W-1:0] off_cnt_q;
  logic             qual_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      on_cnt_q  <= '0;
      off_cnt_q <= '0;
      qual_q    <= 1'b0;
    end else if (!qual_q) begin
      off_cnt_q <= '0;
      if (!s_s) begin
        on_cnt_q <= '0;
      end else if (on_cnt_q == ON_LAST) begin
        on_cnt_q <= '0;
        qual_q   <= 1'b1;
      end else begin
        on_cnt_q <= on_cnt_q + ON_W'(1);
      end
    end else begin
      on_cnt_q <= '0;
      if (s_s) begin
        off_cnt_q <= '0;
      end else if (off_cnt_q == OFF_LAST) begin
        off_cnt_q <= '0;
        qual_q    <= 1'b0;
      end else begin
        off_cnt_q <= off_cnt_q + OFF_W'(1);
      end
    end
  end

  assign walk_button = button_q;
  assign sensor_q    = qual_q;
  assign walk_wait   = wait_q;
  assign walk_stale  = ({1'b0, wait_q} >= STALE_C);

endmodule

`default_nettype wire

// File: tb/tb_traffic_request_frontend.sv
// ============================================================================
// Module      : tb_traffic_request_frontend
// Description : Self-checking bench for traffic_request_frontend (default and
//               WAIT_W=4 instances) against an event-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_request_frontend;

  logic       clk = 1'b0;
  logic       rst;
  logic       walk_raw;
  logic       sensor_raw;
  logic       walk_light;
  logic       walk_button;
  logic       sensor_q;
  logic [7:0] walk_wait;
  logic       walk_stale;
  logic       b4;
  logic       q4;
  logic [3:0] w4;
  logic       st4;

  int checks = 0;
  int errors = 0;

  traffic_request_frontend dut (
    .clk         (clk),
    .rst         (rst),
    .walk_raw    (walk_raw),
    .sensor_raw  (sensor_raw),
    .walk_light  (walk_light),
    .walk_button (walk_button),
    .sensor_q    (sensor_q),
    .walk_wait   (walk_wait),
    .walk_stale  (walk_stale)
  );

  traffic_request_frontend #(.WAIT_W(4), .STALE_LIMIT(10)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .walk_raw    (walk_raw),
    .sensor_raw  (sensor_raw),
    .walk_light  (walk_light),
    .walk_button (b4),
    .sensor_q    (q4),
    .walk_wait   (w4),
    .walk_stale  (st4)
  );

  always #5 clk = ~clk;

  // Reference model: pipeline of synced samples, request/serve flags, run counts
  bit m_w1, m_ws, m_s1, m_ss;
  bit m_req, m_srv, m_sq;
  int m_run, m_wait, m_son, m_soff;

  task automatic model_reset();
    m_w1 = 0; m_ws = 0; m_s1 = 0; m_ss = 0;
    m_req = 0; m_srv = 0; m_sq = 0;
    m_run = 0; m_wait = 0; m_son = 0; m_soff = 0;
  endtask

  task automatic model_edge(input logic wr, input logic sr, input logic wl);
    if (m_srv) begin
      if (!wl && !m_ws) m_srv = 0;
    end else if (m_req) begin
      m_wait++;
      if (wl) begin
        m_req = 0;
        m_srv = 1;
      end
    end else if (m_ws) begin
      if (m_run == 0) m_wait = 0;
      m_run++;
      if (m_run == 2) begin
        m_req = 1;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    if (!m_sq) begin
      m_son = m_ss ? m_son + 1 : 0;
      if (m_son == 3) begin m_sq = 1; m_son = 0; end
    end else begin
      m_soff = m_ss ? 0 : m_soff + 1;
      if (m_soff == 2) begin m_sq = 0; m_soff = 0; end
    end
    m_ws = m_w1; m_w1 = wr;
    m_ss = m_s1; m_s1 = sr;
  endtask

  function automatic logic [10:0] exp8();
    int w;
    w = (m_wait > 255) ? 255 : m_wait;
    return {m_req, m_sq, w[7:0], (w >= 30)};
  endfunction

  function automatic logic [6:0] exp4();
    int w;
    w = (m_wait > 15) ? 15 : m_wait;
    return {m_req, m_sq, w[3:0], (w >= 10)};
  endfunction

  task automatic tick();
    logic wr, sr, wl;
    wr = walk_raw; sr = sensor_raw; wl = walk_light;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(wr, sr, wl);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; walk_raw = 1'b0; sensor_raw = 1'b0; walk_light = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({walk_button, sensor_q, walk_wait, walk_stale} !== 11'd0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h expected=000", i, {walk_button, sensor_q, walk_wait, walk_stale});
      end
      checks++;
      if ({b4, q4, w4, st4} !== 7'd0) begin
        errors++;
        $display("FAIL reset_idle_w4 cyc=%0d got=%h expected=00", i, {b4, q4, w4, st4});
      end
    end
  endtask

  task automatic test_walk();
    walk_raw = 1'b1; tick(); walk_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (walk_button !== 1'b0) begin
        errors++;
        $display("FAIL glitch_button cyc=%0d got=%b expected=0", i, walk_button);
      end
    end
    walk_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 5) walk_raw = 1'b0;
      checks++;
      if (walk_button !== (i >= 4)) begin
        errors++;
        $display("FAIL press_latency edge=%0d got=%b expected=%b", i, walk_button, (i >= 4));
      end
    end
    walk_light = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({walk_button, walk_wait} !== {1'b0, 8'd5}) begin
        errors++;
        $display("FAIL serve cyc=%0d got=%b/%0d expected=0/5", i, walk_button, walk_wait);
      end
    end
    walk_light = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({walk_button, sensor_q, walk_wait, walk_stale} !== exp8() || walk_wait !== 8'd5) begin
        errors++;
        $display("FAIL wait_hold cyc=%0d got=%h expected=%h", i, {walk_button, sensor_q, walk_wait, walk_stale}, exp8());
      end
    end
  endtask

  task automatic test_hold_through();
    int   rises;
    logic prev;
    rises = 0; prev = walk_button; walk_raw = 1'b1;
    for (int i = 0; i < 24; i++) begin
      walk_light = (i >= 6 && i < 10);
      tick();
      if (walk_button && !prev) rises++;
      prev = walk_button;
      checks++;
      if ({walk_button, sensor_q, walk_wait, walk_stale} !== exp8()) begin
        errors++;
        $display("FAIL hold_model cyc=%0d got=%h expected=%h", i, {walk_button, sensor_q, walk_wait, walk_stale}, exp8());
      end
    end
    checks++;
    if (rises !== 1 || walk_button !== 1'b0) begin
      errors++;
      $display("FAIL hold_single_request rises=%0d button=%b expected rises=1 button=0", rises, walk_button);
    end
    walk_raw = 1'b0;
    repeat (4) tick();
    walk_raw = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (walk_button && !prev) rises++;
      prev = walk_button;
    end
    checks++;
    if (rises !== 2 || walk_button !== 1'b1) begin
      errors++;
      $display("FAIL hold_repress rises=%0d button=%b expected rises=2 button=1", rises, walk_button);
    end
    walk_light = 1'b1; tick();
    walk_light = 1'b0; walk_raw = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_sensor();
    logic [20:0] pat;
    logic        seen_early;
    pat = 21'b000001110111111001100;  // applied LSB first
    seen_early = 1'b0;
    for (int i = 0; i < 21; i++) begin
      sensor_raw = pat[i];
      tick();
      if (i < 5 && sensor_q) seen_early = 1'b1;
      checks++;
      if (sensor_q !== m_sq) begin
        errors++;
        $display("FAIL sensor_model cyc=%0d got=%b expected=%b", i, sensor_q, m_sq);
      end
      if (i == 10 || i == 15) begin
        checks++;
        if (sensor_q !== 1'b1) begin
          errors++;
          $display("FAIL sensor_hold cyc=%0d got=%b expected=1", i, sensor_q);
        end
      end
    end
    checks++;
    if (seen_early !== 1'b0) begin
      errors++;
      $display("FAIL sensor_short_burst got=%b expected=0", seen_early);
    end
    checks++;
    if (sensor_q !== 1'b0) begin
      errors++;
      $display("FAIL sensor_release got=%b expected=0", sensor_q);
    end
  endtask

  task automatic test_stale();
    int sat;
    walk_raw = 1'b1;
    repeat (4) tick();
    walk_raw = 1'b0;
    checks++;
    if (walk_button !== 1'b1 || walk_wait !== 8'd0) begin
      errors++;
      $display("FAIL stale_start got=%b/%0d expected=1/0", walk_button, walk_wait);
    end
    for (int p = 1; p <= 40; p++) begin
      tick();
      sat = (p > 15) ? 15 : p;
      checks++;
      if (walk_wait !== 8'(p) || walk_stale !== (p >= 30)) begin
        errors++;
        $display("FAIL stale_count p=%0d got=%0d/%b expected=%0d/%b", p, walk_wait, walk_stale, p, (p >= 30));
      end
      checks++;
      if (w4 !== 4'(sat) || st4 !== (sat >= 10)) begin
        errors++;
        $display("FAIL stale_sat4 p=%0d got=%0d/%b expected=%0d/%b", p, w4, st4, sat, (sat >= 10));
      end
    end
    walk_light = 1'b1; tick();
    walk_light = 1'b0;
    repeat (3) tick();
    checks++;
    if ({walk_button, walk_wait, walk_stale, w4} !== {1'b0, 8'd41, 1'b1, 4'd15}) begin
      errors++;
      $display("FAIL stale_freeze got=%b/%0d/%b/%0d expected=0/41/1/15", walk_button, walk_wait, walk_stale, w4);
    end
  endtask

  task automatic test_reset_mid();
    walk_raw = 1'b1; sensor_raw = 1'b1;
    repeat (6) tick();
    walk_raw = 1'b0;
    checks++;
    if (walk_button !== 1'b1 || sensor_q !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup got=%b/%b expected=1/1", walk_button, sensor_q);
    end
    tick();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({walk_button, sensor_q, walk_wait, walk_stale} !== 11'd0 || {b4, q4, w4, st4} !== 7'd0) begin
      errors++;
      $display("FAIL async_reset got=%h/%h expected=000/00", {walk_button, sensor_q, walk_wait, walk_stale}, {b4, q4, w4, st4});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0; sensor_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (walk_button !== 1'b0) begin
        errors++;
        $display("FAIL no_request_after_reset cyc=%0d got=%b expected=0", i, walk_button);
      end
    end
    walk_raw = 1'b1;
    repeat (4) tick();
    checks++;
    if (walk_button !== 1'b1) begin
      errors++;
      $display("FAIL repress_after_reset got=%b expected=1", walk_button);
    end
    walk_light = 1'b1; tick();
    walk_light = 1'b0; walk_raw = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) walk_raw = ~walk_raw;
      if ($urandom_range(0, 3) == 0) sensor_raw = ~sensor_raw;
      if ($urandom_range(0, 9) == 0) walk_light = ~walk_light;
      tick();
      checks++;
      if ({walk_button, sensor_q, walk_wait, walk_stale} !== exp8()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h expected=%h", i, {walk_button, sensor_q, walk_wait, walk_stale}, exp8());
      end
      checks++;
      if ({b4, q4, w4, st4} !== exp4()) begin
        errors++;
        $display("FAIL random_w4 cyc=%0d got=%h expected=%h", i, {b4, q4, w4, st4}, exp4());
      end
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_hold_through();
    test_sensor();
    test_stale();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
